// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the I/D main-memory port arbiter.
// Arbiter FSM states and requester identities.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_BUSY,
    ARB_RESP
  } arb_state_t;

  typedef enum logic {
    PORT_I,
    PORT_D
  } arb_port_t;

  function automatic arb_port_t other_port(
    input arb_port_t p
  );
    return (p == PORT_I) ? PORT_D : PORT_I;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Cache-side request/response and memory-side signals of the arbiter.
// slave: arbiter view; master: caches plus memory view.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);

  logic          i_req_i;
  logic [AW-1:0] i_addr_i;
  logic          i_done_o;
  logic [DW-1:0] i_rdata_o;

  logic          d_req_i;
  logic          d_we_i;
  logic          d_byte_op_i;
  logic [AW-1:0] d_addr_i;
  logic [DW-1:0] d_wdata_i;
  logic          d_done_o;
  logic [DW-1:0] d_rdata_o;

  logic          err_o;

  logic          mem_req_o;
  logic          mem_we_o;
  logic          mem_byte_op_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic          mem_ack_i;
  logic [DW-1:0] mem_rdata_i;

  modport slave (
    input  i_req_i, i_addr_i,
    input  d_req_i, d_we_i, d_byte_op_i,
    input  d_addr_i, d_wdata_i,
    input  mem_ack_i, mem_rdata_i,
    output i_done_o, i_rdata_o,
    output d_done_o, d_rdata_o,
    output err_o,
    output mem_req_o, mem_we_o,
    output mem_byte_op_o,
    output mem_addr_o, mem_wdata_o
  );

  modport master (
    output i_req_i, i_addr_i,
    output d_req_i, d_we_i, d_byte_op_i,
    output d_addr_i, d_wdata_i,
    output mem_ack_i, mem_rdata_i,
    input  i_done_o, i_rdata_o,
    input  d_done_o, d_rdata_o,
    input  err_o,
    input  mem_req_o, mem_we_o,
    input  mem_byte_op_o,
    input  mem_addr_o, mem_wdata_o
  );

endinterface

// File: rtl/mem_port_arbiter_timeout_counter.sv
// Watchdog for an outstanding memory request.
// expired_o flags the last allowed BUSY cycle.
module arb_timeout_counter #(
  parameter int TIMEOUT = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt <= '0;
    end else if (clear_i) begin
      cnt <= '0;
    end else if (enable_i) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expired_o = enable_i &&
                     (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin sharing of one memory port between I and D caches.
// IDLE -> BUSY (request on bus) -> RESP (done pulse) -> IDLE.
import mem_arb_pkg::*;

module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 64
) (
  input  logic            clk_i,
  input  logic            rst_i,
  mem_port_arbiter_if.slave bus
);

  arb_state_t state;
  arb_port_t  grant_id;
  arb_port_t  last_grant;
  arb_port_t  pick;
  logic       any_req;
  logic       timer_clr;
  logic       timer_en;
  logic       expired;

  assign any_req = bus.i_req_i | bus.d_req_i;

  // Tie goes to the side that did not win last time.
  always_comb begin
    pick = PORT_I;
    if (bus.i_req_i && bus.d_req_i) begin
      pick = other_port(last_grant);
    end else if (bus.d_req_i) begin
      pick = PORT_D;
    end
  end

  assign timer_clr = (state == ARB_IDLE) && any_req;
  assign timer_en  = (state == ARB_BUSY);

  arb_timeout_counter #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (timer_clr),
    .enable_i (timer_en),
    .expired_o(expired)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state             <= ARB_IDLE;
      grant_id          <= PORT_I;
      last_grant        <= PORT_D;
      bus.mem_req_o     <= 1'b0;
      bus.mem_we_o      <= 1'b0;
      bus.mem_byte_op_o <= 1'b0;
      bus.mem_addr_o    <= '0;
      bus.mem_wdata_o   <= '0;
      bus.i_done_o      <= 1'b0;
      bus.d_done_o      <= 1'b0;
      bus.err_o         <= 1'b0;
      bus.i_rdata_o     <= '0;
      bus.d_rdata_o     <= '0;
    end else begin
      bus.i_done_o <= 1'b0;
      bus.d_done_o <= 1'b0;
      bus.err_o    <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (any_req) begin
            state         <= ARB_BUSY;
            grant_id      <= pick;
            last_grant    <= pick;
            bus.mem_req_o <= 1'b1;
            if (pick == PORT_D) begin
              bus.mem_we_o      <= bus.d_we_i;
              bus.mem_byte_op_o <= bus.d_byte_op_i;
              bus.mem_addr_o    <= bus.d_addr_i;
              bus.mem_wdata_o   <= bus.d_wdata_i;
            end else begin
              bus.mem_we_o      <= 1'b0;
              bus.mem_byte_op_o <= 1'b0;
              bus.mem_addr_o    <= bus.i_addr_i;
              bus.mem_wdata_o   <= '0;
            end
          end
        end
        ARB_BUSY: begin
          // Ack beats a coincident timeout.
          if (bus.mem_ack_i || expired) begin
            state         <= ARB_RESP;
            bus.mem_req_o <= 1'b0;
            bus.err_o     <= ~bus.mem_ack_i;
            bus.i_done_o  <= (grant_id == PORT_I);
            bus.d_done_o  <= (grant_id == PORT_D);
          end
          if (bus.mem_ack_i && !bus.mem_we_o) begin
            if (grant_id == PORT_I) begin
              bus.i_rdata_o <= bus.mem_rdata_i;
            end else begin
              bus.d_rdata_o <= bus.mem_rdata_i;
            end
          end
        end
        ARB_RESP: begin
          state <= ARB_IDLE;
        end
        default: begin
          state <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter.
// Transaction-level model predicts grants, bus fields and done timing.
module tb_mem_port_arbiter;

  localparam int T   = 8;
  localparam int NTX = 40;

  typedef struct {
    int          side;
    logic        err;
    logic [31:0] rdata;
    int          at;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;
  exp_t sb[$];

  mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_port_arbiter #(
    .AW(32), .DW(32), .TIMEOUT(T)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(
    input string       nm,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation per done pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.i_done_o && bus.d_done_o)
        chk("done_overlap", 1, 0);
      if (bus.i_done_o || bus.d_done_o) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("done_side", {63'd0, bus.d_done_o}, e.side);
          chk("done_cycle", cyc, e.at);
          chk("done_err", {63'd0, bus.err_o}, {63'd0, e.err});
          if (e.side == 1)
            chk("d_rdata", bus.d_rdata_o, e.rdata);
          else
            chk("i_rdata", bus.i_rdata_o, e.rdata);
        end
      end else if (bus.err_o) begin
        chk("err_without_done", 1, 0);
      end
    end
  end

  logic        req[2];
  logic [31:0] addr[2];
  logic [31:0] wdata[2];
  logic        we[2];
  logic        bo[2];
  logic [31:0] exp_rd[2];
  logic [31:0] ack_data;
  bit          active[2];
  int          gap[2];
  int          issued[2];
  int          finished[2];
  int          done_at[2];
  int          last, g, kk, free_edge, ack_at, w;
  bit          to, in_win;
  exp_t        ne;

  task automatic drive();
    bus.i_req_i     = req[0];
    bus.i_addr_i    = addr[0];
    bus.d_req_i     = req[1];
    bus.d_we_i      = we[1];
    bus.d_byte_op_i = bo[1];
    bus.d_addr_i    = addr[1];
    bus.d_wdata_i   = wdata[1];
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      req[s] = 0; addr[s] = 0; wdata[s] = 0;
      we[s] = 0; bo[s] = 0; exp_rd[s] = 0;
      active[s] = 0; gap[s] = 0;
      issued[s] = 0; finished[s] = 0;
      done_at[s] = -1;
    end
    drive();
    bus.mem_ack_i   = 1'b0;
    bus.mem_rdata_i = '0;
    last = 1; g = -100; kk = 0; ack_at = -1;

    repeat (2) @(negedge clk);
    chk("rst_mem_req", bus.mem_req_o, 0);
    chk("rst_mem_addr", bus.mem_addr_o, 0);
    chk("rst_mem_we", bus.mem_we_o, 0);
    chk("rst_mem_wdata", bus.mem_wdata_o, 0);
    chk("rst_i_done", bus.i_done_o, 0);
    chk("rst_d_done", bus.d_done_o, 0);
    chk("rst_err", bus.err_o, 0);
    chk("rst_i_rdata", bus.i_rdata_o, 0);
    chk("rst_d_rdata", bus.d_rdata_o, 0);

    // First tie: I must win.
    rst = 1'b0;
    free_edge = cyc + 1;
    req[0] = 1; addr[0] = 32'h100;
    req[1] = 1; addr[1] = 32'h200;
    active[0] = 1; active[1] = 1;
    issued[0] = 1; issued[1] = 1;
    drive();

    while (!(finished[0] == NTX && finished[1] == NTX
             && cyc >= free_edge)) begin
      @(negedge clk);
      if (cyc > 20000) begin
        chk("run_timeout", 1, 0);
        break;
      end
      if (cyc >= free_edge && (req[0] || req[1])) begin
        if (req[0] && req[1]) w = 1 - last;
        else w = req[1] ? 1 : 0;
        last = w;
        chk("grant_addr", bus.mem_addr_o, addr[w]);
        chk("grant_we", bus.mem_we_o, (w == 1) ? we[1] : 0);
        chk("grant_byte", bus.mem_byte_op_o,
            (w == 1) ? bo[1] : 0);
        chk("grant_wdata", bus.mem_wdata_o,
            (w == 1) ? wdata[1] : 0);
        to = ($urandom_range(0, 3) == 0);
        if (to || $urandom_range(0, 2) == 0) kk = T - 1;
        else kk = $urandom_range(0, 3);
        g = cyc;
        ack_at = to ? -1 : g + kk;
        ack_data = $urandom;
        if (!to && !(w == 1 && we[1])) exp_rd[w] = ack_data;
        ne.side = w;
        ne.err = to;
        ne.rdata = exp_rd[w];
        ne.at = g + kk + 1;
        sb.push_back(ne);
        done_at[w] = g + kk + 1;
        free_edge = g + kk + 3;
      end
      in_win = (cyc >= g && cyc <= g + kk);
      chk("mem_req", bus.mem_req_o, in_win);

      if (cyc == ack_at) begin
        bus.mem_ack_i = 1'b1;
        bus.mem_rdata_i = ack_data;
      end else begin
        bus.mem_ack_i = !in_win && ($urandom_range(0, 5) == 0);
        bus.mem_rdata_i = $urandom;
      end

      for (int s = 0; s < 2; s++) begin
        if (active[s]) begin
          if (cyc == done_at[s]) begin
            active[s] = 0;
            req[s] = 0;
            gap[s] = $urandom_range(0, 4);
            finished[s]++;
          end
        end else if (issued[s] < NTX) begin
          if (gap[s] == 0) begin
            active[s] = 1;
            req[s] = 1;
            issued[s]++;
            addr[s] = $urandom;
            if (s == 1) begin
              we[1] = $urandom_range(0, 1);
              bo[1] = $urandom_range(0, 1);
              wdata[1] = $urandom;
            end
          end else begin
            gap[s]--;
          end
        end
      end
      drive();
    end

    chk("scoreboard_drain", sb.size(), 0);

    // Reset while BUSY, then stray acks in IDLE.
    @(negedge clk);
    bus.mem_ack_i = 1'b0;
    bus.i_req_i = 1'b1;
    bus.i_addr_i = 32'h40;
    @(negedge clk);
    chk("rb_mem_req_up", bus.mem_req_o, 1);
    chk("rb_mem_addr", bus.mem_addr_o, 32'h40);
    #2 rst = 1'b1;
    #1;
    chk("rb_async_drop", bus.mem_req_o, 0);
    chk("rb_addr_clr", bus.mem_addr_o, 0);
    bus.i_req_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      bus.mem_ack_i = 1'b1;
      bus.mem_rdata_i = $urandom;
      chk("stray_mem_req", bus.mem_req_o, 0);
      chk("stray_i_rdata", bus.i_rdata_o, 0);
      chk("stray_d_rdata", bus.d_rdata_o, 0);
    end
    bus.mem_ack_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("end_drain", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
